// File: rtl/desired_drive_pipe.sv
// desired_drive_pipe
// Fixed-latency, valid-qualified assist-current calculator. Each sample
// carries filtered torque, cadence, incline, assist scale and not_pedaling
// through four register stages. The block produces the motor target current
// for the drive loop 4 cycles after in_vld.
//
// Optional feature: define DESIRED_DRIVE_SLEW_EN to limit how fast
// target_curr can rise. Each update may raise it by at most SLEW_STEP.
// Decreases, including the drop to zero on not_pedaling, take effect at once.
// With the macro undefined, target_curr always equals raw_curr.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   in_vld       in   input sample valid (no backpressure)
//   avg_torque   in   filtered crank torque, unsigned
//   cadence      in   cadence, unsigned
//   not_pedaling in   rider not pedaling, travels with the sample
//   incline      in   incline, signed
//   scale        in   assist level, unsigned
//   out_vld      out  target_curr/raw_curr updated this cycle
//   target_curr  out  motor target current (slew-limited when enabled)
//   raw_curr     out  unslewed computed current of the same sample
module desired_drive_pipe #(
    parameter int unsigned TORQUE_W   = 12,
    parameter int unsigned CAD_W      = 5,
    parameter int unsigned INC_W      = 13,
    parameter int unsigned INC_EFF_W  = 10,
    parameter int unsigned SCALE_W    = 3,
    parameter int unsigned OUT_W      = 12,
    parameter int unsigned TORQUE_MIN = 'h380,
    parameter int unsigned CAD_THRESH = 1,
    parameter int unsigned CAD_OFFSET = 32,
    parameter int          INC_OFFSET = 256,
    parameter int unsigned PROD_SHIFT = 15,
    parameter int unsigned SLEW_STEP  = 'h040
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_vld,
    input  logic        [TORQUE_W-1:0] avg_torque,
    input  logic        [CAD_W-1:0]    cadence,
    input  logic                       not_pedaling,
    input  logic signed [INC_W-1:0]    incline,
    input  logic        [SCALE_W-1:0]  scale,
    output logic                       out_vld,
    output logic        [OUT_W-1:0]    target_curr,
    output logic        [OUT_W-1:0]    raw_curr
);

    // Derived widths: every intermediate is kept at full precision.
    localparam int unsigned INC_FAC_W = INC_EFF_W - 1;
    localparam int unsigned CAD_FAC_W = $clog2((1 << CAD_W) + CAD_OFFSET);
    localparam int unsigned TS_W      = TORQUE_W + SCALE_W;
    localparam int unsigned IC_W      = INC_FAC_W + CAD_FAC_W;
    localparam int unsigned PROD_W    = TS_W + IC_W;
    localparam int unsigned TOP_LSB   = PROD_SHIFT + OUT_W;
    // The extended product always has at least one bit above the output field.
    localparam int unsigned EXT_W     = (PROD_W > TOP_LSB) ? PROD_W : TOP_LSB + 1;

    localparam int INC_MAX = (1 << (INC_EFF_W - 1)) - 1;
    localparam int INC_MIN = -INC_MAX - 1;

    localparam logic [TORQUE_W-1:0] T_MIN  = TORQUE_W'(TORQUE_MIN);
    localparam logic [CAD_W-1:0]    C_TH   = CAD_W'(CAD_THRESH);
    localparam logic [CAD_FAC_W-1:0] C_OFF = CAD_FAC_W'(CAD_OFFSET);
    localparam logic [OUT_W:0]      STEP   = (OUT_W + 1)'(SLEW_STEP);

`ifdef DESIRED_DRIVE_SLEW_EN
    localparam bit SLEW_EN = 1'b1;
`else
    localparam bit SLEW_EN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Stage 1 combinational conditioning
    // ------------------------------------------------------------------
    logic signed [31:0]          inc_ext_c;
    logic signed [31:0]          inc_sat_c;
    logic signed [31:0]          inc_sum_c;
    logic        [INC_FAC_W-1:0] inc_fac_c;
    logic        [TORQUE_W-1:0]  torque_pos_c;
    logic        [CAD_FAC_W-1:0] cad_fac_c;

    // Saturate incline to the effective range, offset it, then clip to the
    // non-negative factor range.
    always_comb begin
        inc_ext_c = 32'(incline);
        inc_sat_c = inc_ext_c;
        if (inc_ext_c > INC_MAX) begin
            inc_sat_c = INC_MAX;
        end else if (inc_ext_c < INC_MIN) begin
            inc_sat_c = INC_MIN;
        end
        inc_sum_c = inc_sat_c + INC_OFFSET;
        if (inc_sum_c < 0) begin
            inc_fac_c = '0;
        end else if (inc_sum_c > INC_MAX) begin
            inc_fac_c = INC_FAC_W'(INC_MAX);
        end else begin
            inc_fac_c = INC_FAC_W'(inc_sum_c);
        end
    end

    // Torque above the dead band, and cadence factor above threshold.
    always_comb begin
        torque_pos_c = (avg_torque > T_MIN) ? (avg_torque - T_MIN) : '0;
        cad_fac_c    = (cadence > C_TH) ? (CAD_FAC_W'(cadence) + C_OFF) : '0;
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic                 s1_vld;
    logic                 s1_np;
    logic [TORQUE_W-1:0]  s1_torque_pos;
    logic [SCALE_W-1:0]   s1_scale;
    logic [INC_FAC_W-1:0] s1_inc_fac;
    logic [CAD_FAC_W-1:0] s1_cad_fac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld        <= 1'b0;
            s1_np         <= 1'b0;
            s1_torque_pos <= '0;
            s1_scale      <= '0;
            s1_inc_fac    <= '0;
            s1_cad_fac    <= '0;
        end else begin
            s1_vld <= in_vld;
            if (in_vld) begin
                s1_np         <= not_pedaling;
                s1_torque_pos <= torque_pos_c;
                s1_scale      <= scale;
                s1_inc_fac    <= inc_fac_c;
                s1_cad_fac    <= cad_fac_c;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: partial products
    // ------------------------------------------------------------------
    logic            s2_vld;
    logic            s2_np;
    logic [TS_W-1:0] s2_ts;
    logic [IC_W-1:0] s2_ic;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld <= 1'b0;
            s2_np  <= 1'b0;
            s2_ts  <= '0;
            s2_ic  <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_np <= s1_np;
                s2_ts <= TS_W'(s1_torque_pos) * TS_W'(s1_scale);
                s2_ic <= IC_W'(s1_inc_fac) * IC_W'(s1_cad_fac);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: full-width product
    // ------------------------------------------------------------------
    logic              s3_vld;
    logic              s3_np;
    logic [PROD_W-1:0] s3_prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_vld  <= 1'b0;
            s3_np   <= 1'b0;
            s3_prod <= '0;
        end else begin
            s3_vld <= s2_vld;
            if (s2_vld) begin
                s3_np   <= s2_np;
                s3_prod <= PROD_W'(s2_ts) * PROD_W'(s2_ic);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3 output: select the current field, saturate on overflow
    // ------------------------------------------------------------------
    logic [EXT_W-1:0] prod_ext_c;
    logic             ovf_c;
    logic [OUT_W-1:0] raw_c;

    always_comb begin
        prod_ext_c = EXT_W'(s3_prod);
        ovf_c      = |prod_ext_c[EXT_W-1:TOP_LSB];
        raw_c      = prod_ext_c[PROD_SHIFT +: OUT_W];
        if (s3_np) begin
            raw_c = '0;
        end else if (ovf_c) begin
            raw_c = '1;
        end
    end

    // Upward slew limit; the step sum carries one extra bit so it cannot wrap.
    logic [OUT_W:0]   step_sum_c;
    logic [OUT_W-1:0] slew_c;
    logic [OUT_W-1:0] target_nxt_c;

    always_comb begin
        step_sum_c = {1'b0, target_curr} + STEP;
        slew_c     = raw_c;
        if ((raw_c > target_curr) && (step_sum_c < {1'b0, raw_c})) begin
            slew_c = step_sum_c[OUT_W-1:0];
        end
        target_nxt_c = SLEW_EN ? slew_c : raw_c;
    end

    // ------------------------------------------------------------------
    // Stage 4: output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld     <= 1'b0;
            raw_curr    <= '0;
            target_curr <= '0;
        end else begin
            out_vld <= s3_vld;
            if (s3_vld) begin
                raw_curr    <= raw_c;
                target_curr <= target_nxt_c;
            end
        end
    end

endmodule

// File: doc/desired_drive_pipe.md
Name: desired_drive_pipe

Overview:
- Parametrised, valid-qualified successor to the e-bike assist-current calculator.
- Takes filtered torque, cadence, incline and scale from the sensing front end, and produces the motor target current for the brushless drive / PID loop.
- Adds a fixed-latency valid pipeline, generic widths and constants, and an optional upward slew limiter on the output current.

Parameters:
- TORQUE_W, 12, avg_torque width
- CAD_W, 5, cadence width
- INC_W, 13, incline width (signed)
- INC_EFF_W, 10, effective incline range after saturation (signed)
- SCALE_W, 3, assist scale width
- OUT_W, 12, target_curr width
- TORQUE_MIN, 12'h380, torque offset subtracted before assist
- CAD_THRESH, 1, cadence must exceed this for assist
- CAD_OFFSET, 32, added to cadence when above threshold
- INC_OFFSET, 256, added to saturated incline
- PROD_SHIFT, 15, product LSB position of target_curr
- SLEW_STEP, 12'h040, max upward change of target_curr per output update

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_vld  in  1  input sample valid; may be high every cycle; no backpressure
- avg_torque  in  TORQUE_W  filtered crank torque, unsigned
- cadence  in  CAD_W  cadence, unsigned
- not_pedaling  in  1  rider not pedaling
- incline  in  INC_W  incline, signed
- scale  in  SCALE_W  assist level, unsigned
- out_vld  out  1  target_curr updated this cycle
- target_curr  out  OUT_W  motor target current, unsigned
- raw_curr  out  OUT_W  unslewed computed current for the same sample

Behaviour:
- Clocking and reset
  - One clock domain.
  - Reset is asynchronous, active-low. All pipeline data, valids, out_vld, raw_curr and target_curr reset to 0.
- Latency
  - out_vld asserts exactly 4 cycles after in_vld; one output per input; back-to-back samples pass without bubbles.
  - All inputs, including not_pedaling, are captured with in_vld and travel with the sample. Non-valid cycles do not disturb stages holding valid data.
- Stage 1
  - incline_sat = incline saturated to signed INC_EFF_W: min -2^(INC_EFF_W-1), max 2^(INC_EFF_W-1)-1.
  - inc_fac = incline_sat + INC_OFFSET, clipped to [0, 2^(INC_EFF_W-1)-1] (511 by default).
  - torque_pos = avg_torque - TORQUE_MIN if positive, else 0.
  - cad_fac = cadence + CAD_OFFSET if cadence > CAD_THRESH, else 0.
- Stage 2: registers ts = torque_pos*scale and ic = inc_fac*cad_fac, both unsigned, full width.
- Stage 3: registers prod = ts*ic, full width, no truncation.
- Stage 3 output → raw
  - If the sample's not_pedaling = 1, raw = 0.
  - Else if any prod bit at or above PROD_SHIFT+OUT_W is set, raw = all ones.
  - Else raw = prod[PROD_SHIFT+OUT_W-1:PROD_SHIFT].
- Stage 4: raw_curr <= raw; target_curr updated per the slew rule; out_vld pulses for 1 cycle.
- Reset mid-pipeline discards all in-flight samples; no out_vld follows for them.

Optional Feature:
- Macro: DESIRED_DRIVE_SLEW_EN.
- Defined:
  - On each stage-4 update, if raw <= target_curr, then target_curr <= raw; decreases and zero on not_pedaling are immediate.
  - Otherwise target_curr <= min(raw, target_curr + SLEW_STEP); the add must not wrap.
- Undefined: target_curr <= raw on each update; target_curr always equals raw_curr.

Test Plan:
- Nominal: avg_torque=0x480, scale=4, incline=0, cadence=16, not_pedaling=0, single in_vld → out_vld 4 cycles later; raw_curr=0x180. target_curr=0x180 without slew; 0x040 with DESIRED_DRIVE_SLEW_EN.
- Slew ramp (macro on): repeat the nominal sample every cycle from target_curr=0 → target_curr steps 0x040, 0x080, … 0x180 on successive out_vld pulses, then holds at 0x180.
- Saturation: avg_torque=0xFFF, scale=7, incline=13'h0FFF, cadence=31 → raw_curr=0xFFF.
- Clipping: avg_torque=0x300 (below TORQUE_MIN), or cadence=1, or incline=13'h1E00 (inc_fac clipped to 0) → raw_curr=0.
- not_pedaling: after reaching 0x180, one sample with not_pedaling=1 → target_curr=0 on that out_vld, with or without the macro.
- Reset mid-flight: in_vld for 2 cycles, assert rst_n low for 1 cycle → outputs 0 immediately; no out_vld afterwards; a next sample produces correct output 4 cycles after its in_vld.
